// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types for the synctimer blocks (adjust stage and local timer).
package jellyvl_synctimer_pkg;

  localparam int TIME_WIDTH = 64;

  typedef logic [TIME_WIDTH-1:0] t_time;

  typedef enum logic {
    TRIG_ARMED = 1'b0,
    TRIG_DONE  = 1'b1
  } t_trig_state;

  // The +1 bit keeps frac + STEP_FRAC (< 2*DENOMINATOR) from overflowing.
  function automatic int frac_width(input int denominator);
    return $clog2(denominator) + 1;
  endfunction

endpackage

// File: rtl/jellyvl_synctimer_timer_if.sv
// Adjust request handshake between the synctimer adjust stage and the timer.
interface jellyvl_synctimer_timer_if;

  logic adjust_sign;
  logic adjust_valid;
  logic adjust_ready;

  modport master (
    output adjust_sign,
    output adjust_valid,
    input  adjust_ready
  );

  modport slave (
    input  adjust_sign,
    input  adjust_valid,
    output adjust_ready
  );

endinterface

// File: rtl/jellyvl_synctimer_trigger.sv
// Periodic / one-shot trigger compared against the registered local time.
//
//   state      | meaning
//   TRIG_ARMED | waiting for current_time to reach next_trig
//   TRIG_DONE  | one-shot already fired, silent until re-armed
module jellyvl_synctimer_trigger
  import jellyvl_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH = TIME_WIDTH,
  parameter int TRIG_WIDTH  = 32
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic [TIMER_WIDTH-1:0] current_time,
  input  logic                   set_valid,
  input  logic                   trig_enable,
  input  logic [TIMER_WIDTH-1:0] param_trig_start,
  input  logic [TRIG_WIDTH-1:0]  param_trig_period,
  output logic                   trig_valid
);

  t_trig_state            state;
  t_trig_state            state_next;
  logic [TIMER_WIDTH-1:0] next_trig;
  logic [TIMER_WIDTH-1:0] next_trig_next;
  logic [TIMER_WIDTH-1:0] diff;
  logic                   fire;

  always_comb begin
    state_next     = state;
    next_trig_next = next_trig;
    fire           = 1'b0;
    // Signed difference keeps the compare correct across wrap-around.
    diff           = current_time - next_trig;
    if (set_valid || !trig_enable) begin
      state_next     = TRIG_ARMED;
      next_trig_next = param_trig_start;
    end else if (state == TRIG_ARMED && !diff[TIMER_WIDTH-1]) begin
      fire = 1'b1;
      if (param_trig_period == '0) begin
        state_next = TRIG_DONE;
      end else begin
        next_trig_next = next_trig + TIMER_WIDTH'(param_trig_period);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= TRIG_ARMED;
      next_trig  <= param_trig_start;
      trig_valid <= 1'b0;
    end else begin
      state      <= state_next;
      next_trig  <= next_trig_next;
      trig_valid <= fire;
    end
  end

endmodule

// File: rtl/jellyvl_synctimer_timer.sv
// Local time-of-day counter with rational nominal step, +/-1 adjust,
// hard override and periodic trigger output.
module jellyvl_synctimer_timer
  import jellyvl_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH = TIME_WIDTH,
  parameter int NUMERATOR   = 10,
  parameter int DENOMINATOR = 3,
  parameter int TRIG_WIDTH  = 32
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic [TIMER_WIDTH-1:0]   set_time,
  input  logic                     set_valid,
  jellyvl_synctimer_timer_if.slave adj,
  input  logic                     trig_enable,
  input  logic [TIMER_WIDTH-1:0]   param_trig_start,
  input  logic [TRIG_WIDTH-1:0]    param_trig_period,
  output logic [TIMER_WIDTH-1:0]   current_time,
  output logic                     trig_valid
);

  localparam int STEP_INT  = NUMERATOR / DENOMINATOR;
  localparam int STEP_FRAC = NUMERATOR % DENOMINATOR;
  localparam int FRAC_W    = frac_width(DENOMINATOR);

  logic [FRAC_W-1:0]      frac;
  logic [FRAC_W-1:0]      frac_sum;
  logic [FRAC_W-1:0]      frac_next;
  logic                   carry;
  logic                   adj_accept;
  logic [TIMER_WIDTH-1:0] time_next;

  assign adj.adjust_ready = !reset && !set_valid;
  assign adj_accept       = adj.adjust_valid && adj.adjust_ready;

  always_comb begin
    frac_sum  = frac + FRAC_W'(STEP_FRAC);
    carry     = (frac_sum >= FRAC_W'(DENOMINATOR));
    frac_next = carry ? (frac_sum - FRAC_W'(DENOMINATOR)) : frac_sum;
    time_next = current_time + TIMER_WIDTH'(STEP_INT)
              + {{(TIMER_WIDTH-1){1'b0}}, carry};
    if (adj_accept) begin
      time_next = adj.adjust_sign ? (time_next - TIMER_WIDTH'(1))
                                  : (time_next + TIMER_WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_time <= '0;
      frac         <= '0;
    end else if (set_valid) begin
      current_time <= set_time;
      frac         <= '0;
    end else begin
      current_time <= time_next;
      frac         <= frac_next;
    end
  end

  jellyvl_synctimer_trigger #(
    .TIMER_WIDTH (TIMER_WIDTH),
    .TRIG_WIDTH  (TRIG_WIDTH)
  ) u_trigger (
    .reset             (reset),
    .clk               (clk),
    .current_time      (current_time),
    .set_valid         (set_valid),
    .trig_enable       (trig_enable),
    .param_trig_start  (param_trig_start),
    .param_trig_period (param_trig_period),
    .trig_valid        (trig_valid)
  );

endmodule
